// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: queues decoded branches with predictions, resolves them in order, drives predictor update, redirect and flush
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_INC = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_is_branch,
  input  logic [31:0] d_pc,
  input  logic        d_pred_taken,
  input  logic [31:0] d_pred_addr,
  input  logic        x_resolve,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic        stall_d,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_hit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        err_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [CW-1:0] fcnt, fcnt_nx;
  logic [AW:0] rd, wr, cnt;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_pa [DEPTH];
  logic [DEPTH-1:0] q_pt;
  logic run, push, pop, mis;
  logic [31:0] h_pc, h_pa, fix_pc;
  logic h_pt;
  assign stall_d = cnt == (AW+1)'(DEPTH);
  assign flush = state == FLUSH;
  always_comb begin
    run = state == RUN;
    push = run && d_is_branch && !stall_d;
    pop = run && x_resolve && cnt != '0;
    h_pc = q_pc[rd[AW-1:0]];
    h_pa = q_pa[rd[AW-1:0]];
    h_pt = q_pt[rd[AW-1:0]];
    mis = (x_taken != h_pt) || (x_taken && x_target != h_pa);
    fix_pc = x_taken ? x_target : h_pc + PC_INC;
    state_nx = (pop && mis) ? FLUSH : (!run && fcnt == CW'(1)) ? RUN : state;
    fcnt_nx = (pop && mis) ? CW'(FLUSH_CYCLES) : run ? fcnt : fcnt - CW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt <= '0;
    end else begin
      state <= state_nx;
      fcnt <= fcnt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr[AW-1:0]] <= d_pc;
      q_pa[wr[AW-1:0]] <= d_pred_addr;
      q_pt[wr[AW-1:0]] <= d_pred_taken;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      upd_valid <= 1'b0;
      upd_pc <= '0;
      upd_target <= '0;
      upd_taken <= 1'b0;
      upd_hit <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= pop;
      upd_hit <= pop && !mis;
      redirect_valid <= pop && mis;
      err_underflow <= err_underflow || (run && x_resolve && cnt == '0);
      if (pop) begin
        upd_pc <= h_pc;
        upd_target <= x_target;
        upd_taken <= x_taken;
      end
      if (pop && mis) begin
        redirect_pc <= fix_pc;
        rd <= '0;
        wr <= '0;
        cnt <= '0;
      end else begin
        rd <= rd + (AW+1)'(pop);
        wr <= wr + (AW+1)'(push);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed checks of queueing, resolve, flush, stall, underflow and async reset
module tb_branch_resolve_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic d_is_branch, d_pred_taken, x_resolve, x_taken;
  logic [31:0] d_pc, d_pred_addr, x_target;
  logic stall_d, upd_valid, upd_taken, upd_hit, redirect_valid, flush, err_underflow;
  logic [31:0] upd_pc, upd_target, redirect_pc;
  int passed = 0;
  int fails = 0;
  int total = 0;
  branch_resolve_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .d_is_branch(d_is_branch), .d_pc(d_pc), .d_pred_taken(d_pred_taken), .d_pred_addr(d_pred_addr),
    .x_resolve(x_resolve), .x_taken(x_taken), .x_target(x_target),
    .stall_d(stall_d), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_hit(upd_hit), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] pa);
    d_is_branch = 1'b1;
    d_pc = pc;
    d_pred_taken = pt;
    d_pred_addr = pa;
  endtask
  task automatic resolve(input logic tk, input logic [31:0] tg);
    x_resolve = 1'b1;
    x_taken = tk;
    x_target = tg;
  endtask
  task automatic idle();
    d_is_branch = 1'b0;
    x_resolve = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    d_pc = '0;
    d_pred_taken = 1'b0;
    d_pred_addr = '0;
    x_taken = 1'b0;
    x_target = '0;
    #3;
    chk("reset_flags", {upd_valid, upd_taken, upd_hit, redirect_valid, flush, err_underflow, stall_d}, 0);
    chk("reset_upd_pc", upd_pc, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // correct not-taken prediction
    push(32'h10, 1'b0, 32'h0);
    cyc();
    idle();
    resolve(1'b0, 32'h0);
    cyc();
    idle();
    chk("cp_upd_valid", upd_valid, 1);
    chk("cp_upd_pc", upd_pc, 32'h10);
    chk("cp_upd_hit", upd_hit, 1);
    chk("cp_redirect", redirect_valid, 0);
    chk("cp_flush", flush, 0);
    cyc();
    chk("cp_upd_once", {upd_valid, upd_hit}, 0);
    // taken with wrong target
    push(32'h20, 1'b1, 32'h40);
    cyc();
    idle();
    resolve(1'b1, 32'h44);
    cyc();
    idle();
    chk("wt_upd_hit", {upd_valid, upd_hit, upd_taken}, 3'b101);
    chk("wt_upd_target", upd_target, 32'h44);
    chk("wt_redirect_valid", redirect_valid, 1);
    chk("wt_redirect_pc", redirect_pc, 32'h44);
    chk("wt_flush1", flush, 1);
    cyc();
    chk("wt_flush2", {flush, redirect_valid}, 2'b10);
    cyc();
    chk("wt_flush_end", flush, 0);
    chk("wt_count", dut.cnt, 0);
    // not-taken mispredict at the top of the address space
    push(32'hFFFF_FFFF, 1'b1, 32'h100);
    cyc();
    idle();
    resolve(1'b0, 32'h0);
    cyc();
    idle();
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_redirect_valid", redirect_valid, 1);
    cyc();
    cyc();
    chk("wrap_flush_end", flush, 0);
    // full queue
    for (int i = 0; i < 4; i++) begin
      chk("full_no_stall", stall_d, 0);
      push(32'h100 + i, 1'b0, 32'h0);
      cyc();
    end
    push(32'h104, 1'b0, 32'h0);
    chk("full_stall", stall_d, 1);
    cyc();
    chk("full_hold_stall", stall_d, 1);
    chk("full_count", dut.cnt, 4);
    resolve(1'b0, 32'h0);
    chk("full_stall_at_pop", stall_d, 1);
    cyc();
    x_resolve = 1'b0;
    chk("full_release", stall_d, 0);
    chk("full_pop_pc", upd_pc, 32'h100);
    cyc();
    idle();
    chk("full_fifth_in", stall_d, 1);
    resolve(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("full_drain_pc", upd_pc, 32'h101 + i);
    end
    idle();
    chk("full_drained", dut.cnt, 0);
    // simultaneous push and pop
    push(32'h200, 1'b0, 32'h0);
    cyc();
    push(32'h204, 1'b1, 32'h300);
    cyc();
    chk("sim_count2", dut.cnt, 2);
    push(32'h208, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    cyc();
    chk("sim_count_hold", dut.cnt, 2);
    chk("sim_hit", {upd_valid, upd_hit}, 2'b11);
    chk("sim_pc", upd_pc, 32'h200);
    push(32'h20C, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    cyc();
    chk("sim_mis_count", dut.cnt, 0);
    chk("sim_mis_redirect", redirect_pc, 32'h205);
    chk("sim_mis_flush", flush, 1);
    cyc();
    idle();
    chk("sim_ignored_count", dut.cnt, 0);
    chk("sim_ignored_flags", {flush, upd_valid, err_underflow}, 3'b100);
    cyc();
    chk("sim_flush_end", flush, 0);
    push(32'h300, 1'b0, 32'h0);
    cyc();
    idle();
    chk("sim_accept_after", dut.cnt, 1);
    resolve(1'b0, 32'h0);
    cyc();
    idle();
    chk("sim_empty", dut.cnt, 0);
    // underflow and reset mid-flush
    resolve(1'b0, 32'h0);
    cyc();
    idle();
    chk("uf_set", {err_underflow, upd_valid}, 2'b10);
    cyc();
    chk("uf_held", err_underflow, 1);
    push(32'h400, 1'b1, 32'h500);
    cyc();
    idle();
    resolve(1'b1, 32'h600);
    cyc();
    idle();
    chk("rst_pre_flush", flush, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flags", {upd_valid, upd_taken, upd_hit, redirect_valid, flush, err_underflow, stall_d}, 0);
    chk("rst_pcs", upd_pc | upd_target | redirect_pc, 0);
    chk("rst_count", dut.cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_state_run", 32'(dut.state), 0);
    push(32'h700, 1'b0, 32'h0);
    cyc();
    idle();
    resolve(1'b0, 32'h0);
    cyc();
    idle();
    chk("rst_run_pop", {upd_valid, upd_hit, flush}, 3'b110);
    chk("rst_run_pc", upd_pc, 32'h700);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencing controller for `branch_predictor`. It queues every branch leaving DECODE together with its prediction, matches each queued branch against the EXEC resolution in program order, and drives the predictor update and fetch redirect. On a misprediction it issues a fixed-length pipeline flush. It sits between the decode/exec stages and `branch_predictor`, and it is the single source of the predictor's training feedback.

## Interface
- `DEPTH`, 4: in-flight branch queue entries; power of two, at least 2.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a mispredict; at least 1.
- `PC_INC`, 1: fall-through PC increment, matching fetch's PC step.

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d_is_branch`  in  1  DECODE holds a branch this cycle.
- `d_pc`  in  32  PC of the DECODE instruction.
- `d_pred_taken`  in  1  prediction carried with the branch (fetch `f_predict_valid`).
- `d_pred_addr`  in  32  predicted target (fetch `f_predict_addr`).
- `x_resolve`  in  1  EXEC resolves the oldest branch this cycle.
- `x_taken`  in  1  actual direction.
- `x_target`  in  32  actual taken target.
- `stall_d`  out  1  queue full; combinational; DECODE must hold.
- `upd_valid`  out  1  one-cycle predictor update strobe.
- `upd_pc`  out  32  PC of the resolved branch.
- `upd_target`  out  32  actual target.
- `upd_taken`  out  1  actual direction.
- `upd_hit`  out  1  prediction was correct; drives predictor `x_predict_res`.
- `redirect_valid`  out  1  one-cycle fetch redirect strobe.
- `redirect_pc`  out  32  correct-path PC.
- `flush`  out  1  kill all wrong-path instructions younger than the branch.
- `err_underflow`  out  1  sticky error: a resolve arrived with the queue empty.

## Operation
- FSM with two states, RUN and FLUSH. Reset enters RUN.
- Queue is a circular FIFO:
  - Fields: `{pc, pred_taken, pred_addr}`.
  - Read pointer, write pointer and count are each log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- **Push** (RUN only): when `d_is_branch && !stall_d`. `stall_d = (count == DEPTH)`. A `d_is_branch` seen while full is not enqueued; decode re-presents it.
- **Pop** (RUN only): when `x_resolve && count != 0`.
  - A mispredict is `x_taken != head.pred_taken`, or `x_taken && x_target != head.pred_addr`.
  - The correct PC is `x_taken ? x_target : head.pc + PC_INC`, computed mod 2^32.
- **Resolve while empty**: no pop, no update. `err_underflow` is set and held until reset.
- **Simultaneous push and pop, correct prediction**: both take effect; count is unchanged. This is legal at count == DEPTH only if `stall_d` was low, so it is never legal when full.
- **Mispredict pop**:
  - Clears the whole queue (count, read pointer and write pointer to 0), including any push in the same cycle, because those entries are wrong-path.
  - Loads the flush counter with FLUSH_CYCLES and moves to FLUSH.
- **FLUSH state**:
  - `d_is_branch` and `x_resolve` are ignored.
  - The counter decrements each cycle; at 1 the FSM returns to RUN.
- **Outputs at reset**: all outputs are 0, except `stall_d`, which is combinational and is 0 because count = 0.

## Timing
- Resolve-to-output latency is 1 cycle. `upd_*`, `redirect_*` and `flush` are registered and appear on the edge after the `x_resolve` cycle.
- `upd_valid` is high for exactly 1 cycle per successful pop. `upd_hit` is valid only while `upd_valid` is high, and is 0 otherwise.
- `redirect_valid` is high for exactly 1 cycle, coincident with the first `flush` cycle.
- `flush` is high for exactly FLUSH_CYCLES consecutive cycles. The first `d_is_branch` accepted again is in the cycle after `flush` falls.
- `stall_d` reflects the current count with zero latency. A pop does not release the stall in the same cycle.
- Asynchronous reset mid-flush or with the queue non-empty: state, queue, counter and all registered outputs clear immediately. The FSM is in RUN after `rst_n` rises.

## Test plan
- **Correct predict**:
  - Stimulus: push pc=0x10 (pred_taken=0), then resolve with x_taken=0.
  - Required: next cycle `upd_valid`=1, `upd_pc`=0x10, `upd_hit`=1, `redirect_valid`=0, `flush`=0.
- **Wrong target**:
  - Stimulus: push pc=0x20 (pred_taken=1, pred_addr=0x40), then resolve with x_taken=1, x_target=0x44.
  - Required: `upd_hit`=0, `redirect_pc`=0x44, `flush` high for exactly 2 cycles, count=0 afterwards.
- **Not-taken mispredict with PC wrap**:
  - Stimulus: push pc=0xFFFFFFFF (pred_taken=1), then resolve with x_taken=0.
  - Required: `redirect_pc`=0x00000000.
- **Full queue**:
  - Stimulus: 4 pushes with no resolve, then a 5th `d_is_branch`.
  - Required: `stall_d`=1 and the 5th is not enqueued. After one correct resolve, `stall_d`=0 next cycle and the 5th push is accepted.
- **Simultaneous events**:
  - Stimulus: count=2; same-cycle push and correct pop, then same-cycle push and mispredict pop.
  - Required: count stays 2 after the first; count becomes 0 after the second. `d_is_branch`/`x_resolve` during `flush` are ignored.
- **Errors and reset**:
  - Stimulus: `x_resolve` with the queue empty, then `rst_n`=0 asserted mid-flush.
  - Required: `err_underflow`=1 and held. On reset, all outputs are 0 immediately, including `err_underflow`; RUN after release.
